i2c_init_seq: RTL and testbench

Reads the 24-bit I2C initialization words out of the init RAM (64 × 24, registered read) and plays each one onto the I2C bus as a 3-byte write transaction: device address, register address, data. It is the reader and bus master that sits between the init RAM's read port and the open-drain SCL/SDA pad drivers. It starts on a pulse from board bring-up control and reports done or error.

---
 rtl/i2c_init_seq.sv | 302 ++++++++++++++++++++++++++++++
 tb/tb_i2c_init_seq.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_init_seq.sv
// i2c_init_seq
// Reads 24-bit init words from a 64 x 24 RAM (registered read) and plays
// each one onto the I2C bus as a 3-byte write: device, register, data.
// A word equal to TERM_WORD ends the sequence. Entry 63 is the last entry.
//
// Optional feature, macro I2C_INIT_NACK_RETRY_EN: a NACKed entry is retried
// after its STOP, up to MAX_RETRY times, before the block reports error.
// Without the macro the first NACK ends the sequence with error.
//
// Timing contract with the neighbours: start is a one-cycle pulse that is
// acted on only while busy=0; ram_data must reflect ram_addr one clk after
// ram_addr changes, and ram_addr is held for the whole FETCH/WAIT/CHECK run.
//
// Bus timing: one I2C bit is four quarters of CLK_DIV clk each. The pads
// are open-drain enables (1 = pull low) and only change at quarter starts.
module i2c_init_seq #(
  parameter int unsigned CLK_DIV   = 125,
  parameter logic [23:0] TERM_WORD = 24'hFFFFFF,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [5:0]  ram_addr,
  input  logic [23:0] ram_data,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [5:0]  err_index,
  output logic        scl_oe,
  output logic        sda_oe,
  input  logic        sda_in,
  output logic [3:0]  state_dbg
);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_FETCH = 4'd1,
    S_WAIT  = 4'd2,
    S_CHECK = 4'd3,
    S_START = 4'd4,
    S_BYTE  = 4'd5,
    S_STOP  = 4'd6,
    S_NEXT  = 4'd7,
    S_DONE  = 4'd8,
    S_ERROR = 4'd9
  } state_t;

  // Last and second-to-last count of a quarter. NEXT borrows the final clk
  // of the bus-free STOP quarter so the gap between transactions is only
  // the three fetch cycles.
  localparam logic [9:0] DIV_LAST = 10'(CLK_DIV - 1);
  localparam logic [9:0] DIV_PRE  = 10'(CLK_DIV - 2);

  // Registered state
  state_t      state;
  logic [9:0]  cnt;        // clk count inside the current quarter
  logic [1:0]  qtr;        // quarter index inside the current bit
  logic [3:0]  bit_cnt;    // 0..7 data bits, 8 = ACK slot
  logic [1:0]  byte_cnt;   // 0 device, 1 register, 2 data
  logic [23:0] shift;      // transmit word, MSB is the bit on the wire
  logic        nack;       // ACK slot of the current byte read back high
  logic [5:0]  idx;        // RAM entry being played

  // Next-state values
  state_t      state_nxt;
  logic [9:0]  cnt_nxt;
  logic [1:0]  qtr_nxt;
  logic [3:0]  bit_nxt;
  logic [1:0]  byte_nxt;
  logic [23:0] shift_nxt;
  logic        nack_nxt;
  logic [5:0]  idx_nxt;
  logic        busy_nxt;
  logic        done_nxt;
  logic        error_nxt;
  logic [5:0]  err_index_nxt;
  logic        scl_nxt;
  logic        sda_nxt;

  // Quarter timing helpers
  logic        q_end;
  logic        q_pre;
  logic [9:0]  cnt_step;
  logic [1:0]  qtr_step;

`ifdef I2C_INIT_NACK_RETRY_EN
  localparam logic [7:0] RETRY_LIMIT = 8'(MAX_RETRY);
  logic [7:0] retry_cnt;
  logic [7:0] retry_nxt;
`else
  logic [31:0] unused_max_retry;
  assign unused_max_retry = MAX_RETRY;
`endif

  assign ram_addr  = idx;
  assign state_dbg = state;

  assign q_end    = (cnt == DIV_LAST);
  assign q_pre    = (cnt == DIV_PRE);
  assign cnt_step = q_end ? 10'd0 : cnt + 10'd1;
  assign qtr_step = q_end ? qtr + 2'd1 : qtr;

  // Sequencer and datapath registers; every output port is a flop
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      qtr       <= '0;
      bit_cnt   <= '0;
      byte_cnt  <= '0;
      shift     <= '0;
      nack      <= 1'b0;
      idx       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      err_index <= '0;
      scl_oe    <= 1'b0;
      sda_oe    <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      qtr       <= qtr_nxt;
      bit_cnt   <= bit_nxt;
      byte_cnt  <= byte_nxt;
      shift     <= shift_nxt;
      nack      <= nack_nxt;
      idx       <= idx_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      error     <= error_nxt;
      err_index <= err_index_nxt;
      scl_oe    <= scl_nxt;
      sda_oe    <= sda_nxt;
    end
  end

`ifdef I2C_INIT_NACK_RETRY_EN
  // Retry counter for the entry currently being played
  always_ff @(posedge clk) begin
    if (rst) begin
      retry_cnt <= '0;
    end else begin
      retry_cnt <= retry_nxt;
    end
  end
`endif

  // Next-state logic: entry fetch, bit/quarter sequencing, ACK handling
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = '0;
    qtr_nxt       = '0;
    bit_nxt       = bit_cnt;
    byte_nxt      = byte_cnt;
    shift_nxt     = shift;
    nack_nxt      = nack;
    idx_nxt       = idx;
    busy_nxt      = busy;
    done_nxt      = done;
    error_nxt     = error;
    err_index_nxt = err_index;
`ifdef I2C_INIT_NACK_RETRY_EN
    retry_nxt     = retry_cnt;
`endif

    case (state)
      // DONE and ERROR last one clk with busy low, then fall back to IDLE;
      // a start seen in any of the three begins a fresh sequence.
      S_IDLE, S_DONE, S_ERROR: begin
        state_nxt = S_IDLE;
        if (start) begin
          state_nxt = S_FETCH;
          idx_nxt   = '0;
          busy_nxt  = 1'b1;
          done_nxt  = 1'b0;
          error_nxt = 1'b0;
`ifdef I2C_INIT_NACK_RETRY_EN
          retry_nxt = '0;
`endif
        end
      end

      S_FETCH: state_nxt = S_WAIT;

      S_WAIT: state_nxt = S_CHECK;

      S_CHECK: begin
        shift_nxt = ram_data;
        if (ram_data == TERM_WORD) begin
          state_nxt = S_DONE;
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
        end else begin
          state_nxt = S_START;
          nack_nxt  = 1'b0;
          bit_nxt   = '0;
          byte_nxt  = '0;
        end
      end

      S_START: begin
        cnt_nxt = cnt_step;
        qtr_nxt = qtr_step;
        if (q_end && (qtr == 2'd3)) begin
          state_nxt = S_BYTE;
        end
      end

      S_BYTE: begin
        cnt_nxt = cnt_step;
        qtr_nxt = qtr_step;
        // ACK is read on the last clk of the first SCL-high quarter
        if (q_end && (qtr == 2'd2) && (bit_cnt == 4'd8)) begin
          nack_nxt = sda_in;
        end
        if (q_end && (qtr == 2'd3)) begin
          if (bit_cnt == 4'd8) begin
            bit_nxt  = '0;
            byte_nxt = byte_cnt + 2'd1;
            if (nack || (byte_cnt == 2'd2)) begin
              state_nxt = S_STOP;
            end
          end else begin
            bit_nxt   = bit_cnt + 4'd1;
            shift_nxt = {shift[22:0], 1'b0};
          end
        end
      end

      S_STOP: begin
        cnt_nxt = cnt_step;
        qtr_nxt = qtr_step;
        if ((qtr == 2'd3) && q_pre) begin
          state_nxt = S_NEXT;
          cnt_nxt   = '0;
          qtr_nxt   = '0;
        end
      end

      // Decide what follows a finished transaction
      S_NEXT: begin
        if (nack) begin
`ifdef I2C_INIT_NACK_RETRY_EN
          if (retry_cnt < RETRY_LIMIT) begin
            retry_nxt = retry_cnt + 8'd1;
            state_nxt = S_FETCH;
          end else begin
            state_nxt     = S_ERROR;
            error_nxt     = 1'b1;
            err_index_nxt = idx;
            busy_nxt      = 1'b0;
          end
`else
          state_nxt     = S_ERROR;
          error_nxt     = 1'b1;
          err_index_nxt = idx;
          busy_nxt      = 1'b0;
`endif
        end else if (idx == 6'd63) begin
          state_nxt = S_DONE;
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
        end else begin
          state_nxt = S_FETCH;
          idx_nxt   = idx + 6'd1;
`ifdef I2C_INIT_NACK_RETRY_EN
          retry_nxt = '0;
`endif
        end
      end

      default: state_nxt = S_IDLE;
    endcase
  end

  // Pad levels for the quarter being entered; released outside a frame
  always_comb begin
    scl_nxt = 1'b0;
    sda_nxt = 1'b0;
    case (state_nxt)
      S_START: begin
        sda_nxt = (qtr_nxt != 2'd0);
        scl_nxt = qtr_nxt[1];
      end
      S_BYTE: begin
        scl_nxt = ~qtr_nxt[1];
        sda_nxt = (bit_nxt != 4'd8) && !shift_nxt[23];
      end
      S_STOP: begin
        scl_nxt = (qtr_nxt == 2'd0);
        sda_nxt = (qtr_nxt <= 2'd1);
      end
      default: begin
        scl_nxt = 1'b0;
        sda_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_i2c_init_seq.sv
// Bench for i2c_init_seq: RAM model, I2C slave/bus monitor, and a
// transaction-level reference model that predicts frames, flags and timing.
module tb_i2c_init_seq;

  localparam int unsigned DIV  = 3;
  localparam logic [23:0] TERM = 24'hFFFFFF;
`ifdef I2C_INIT_NACK_RETRY_EN
  localparam int RETRIES = 3;
`else
  localparam int RETRIES = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [5:0]  ram_addr;
  logic [23:0] ram_data;
  logic        busy;
  logic        done;
  logic        error;
  logic [5:0]  err_index;
  logic        scl_oe;
  logic        sda_oe;
  logic        sda_in;
  logic [3:0]  state_dbg;

  i2c_init_seq #(
    .CLK_DIV(DIV),
    .TERM_WORD(TERM),
    .MAX_RETRY(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .ram_addr(ram_addr),
    .ram_data(ram_data),
    .busy(busy),
    .done(done),
    .error(error),
    .err_index(err_index),
    .scl_oe(scl_oe),
    .sda_oe(sda_oe),
    .sda_in(sda_in),
    .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- init RAM, registered read ----------------
  logic [23:0] ram [64];
  always @(posedge clk) ram_data <= ram[ram_addr];

  // ---------------- open-drain bus and slave ----------------
  logic slave_pull = 1'b0;
  logic scl_line;
  logic sda_line;
  assign scl_line = ~scl_oe;
  assign sda_line = ~(sda_oe | slave_pull);
  assign sda_in   = sda_line;

  int          nack_at [256];   // per frame: byte index the slave NACKs, 3 = none
  logic        mon_clear = 1'b0;
  int          frame_no = 0;
  int          cur_frame = 0;
  logic        prev_scl = 1'b1;
  logic        prev_sda = 1'b1;
  logic        in_frame = 1'b0;
  int          bitn = 0;
  int          fcount = 0;
  logic [7:0]  cur = '0;
  logic [23:0] fbytes = '0;
  logic [25:0] obs_q[$];         // {bytes_sent[1:0], bytes left-aligned}

  always @(negedge clk) begin
    if (mon_clear) begin
      frame_no = 0;
      obs_q.delete();
    end
    if (rst) begin
      slave_pull = 1'b0;
      in_frame   = 1'b0;
      bitn       = 0;
      prev_scl   = 1'b1;
      prev_sda   = 1'b1;
    end else begin
      if (prev_scl && scl_line && prev_sda && !sda_line) begin
        in_frame  = 1'b1;
        bitn      = 0;
        fcount    = 0;
        fbytes    = '0;
        cur_frame = frame_no;
        frame_no++;
      end else if (prev_scl && scl_line && !prev_sda && sda_line) begin
        if (in_frame) obs_q.push_back({fcount[1:0], fbytes});
        in_frame = 1'b0;
      end else if (!prev_scl && scl_line && in_frame) begin
        if (bitn < 8) begin
          cur = {cur[6:0], sda_line};
          bitn++;
        end else begin
          bitn = 0;
        end
      end else if (prev_scl && !scl_line && in_frame) begin
        if (bitn == 8 && fcount < 3) begin
          fbytes[23 - 8*fcount -: 8] = cur;
          slave_pull = (nack_at[cur_frame] != fcount);
          fcount++;
        end else begin
          slave_pull = 1'b0;
        end
      end
      prev_scl = scl_line;
      prev_sda = sda_line;
    end
  end

  // ---------------- scoreboard ----------------
  int          n_vec  = 0;
  int          n_fail = 0;
  logic [25:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_policy();
    for (int i = 0; i < 256; i++) nack_at[i] = 3;
  endtask

  function automatic logic [23:0] rand_word();
    logic [31:0] r;
    r = $urandom();
    r[16] = 1'b0;   // R/W bit of the device byte is a write
    return r[23:0];
  endfunction

  // Play the RAM contents once and compare against the reference model
  task automatic run_seq(input string tag, input bit pulse_again);
    int          m_idx;
    int          m_retries;
    int          m_frame;
    int          nb;
    int          exp_lat;
    int          cyc;
    int          first_sda;
    int          budget;
    bit          fin;
    bit          nacked;
    bit          exp_done;
    bit          exp_err;
    logic [5:0]  exp_eidx;
    logic [23:0] w;
    logic [23:0] mask;

    // reference model: walk the table transaction by transaction
    exp_q.delete();
    m_idx = 0; m_retries = 0; m_frame = 0; exp_lat = 0; fin = 0;
    exp_done = 0; exp_err = 0; exp_eidx = '0;
    while (!fin) begin
      w = ram[m_idx];
      exp_lat += 3;
      if (w == TERM) begin
        exp_done = 1;
        fin = 1;
      end else begin
        nb = 3;
        nacked = 0;
        if (nack_at[m_frame] < 3) begin
          nb = nack_at[m_frame] + 1;
          nacked = 1;
        end
        mask = ~(24'hFFFFFF >> (8*nb));
        exp_q.push_back({nb[1:0], w & mask});
        exp_lat += (8 + 36*nb) * DIV;
        m_frame++;
        if (nacked) begin
          if (m_retries < RETRIES) begin
            m_retries++;
          end else begin
            exp_err = 1;
            exp_eidx = m_idx[5:0];
            fin = 1;
          end
        end else begin
          m_retries = 0;
          if (m_idx == 63) begin
            exp_done = 1;
            fin = 1;
          end else begin
            m_idx++;
          end
        end
      end
    end

    // drive the start pulse
    @(posedge clk); #1;
    mon_clear = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    mon_clear = 1'b0;
    check({tag, "/busy_after_start"}, busy, 1);

    budget = exp_lat + 100;
    cyc = 0;
    first_sda = -1;
    while (cyc < budget) begin
      @(posedge clk); #1;
      cyc++;
      start = (pulse_again && cyc == 50);
      if (sda_oe && first_sda < 0) first_sda = cyc;
      if (done || error) break;
    end
    start = 1'b0;

    check({tag, "/latency"}, cyc, exp_lat);
    check({tag, "/done"}, done, exp_done);
    check({tag, "/error"}, error, exp_err);
    check({tag, "/busy_end"}, busy, 0);
    if (exp_err) check({tag, "/err_index"}, err_index, exp_eidx);
    if (exp_q.size() > 0) check({tag, "/first_sda_fall"}, first_sda, 3 + DIV);
    check({tag, "/frame_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check({tag, "/frame"}, obs_q[i], exp_q[i]);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    rst = 1'b1;
    start = 1'b0;
    clear_policy();
    for (int i = 0; i < 64; i++) ram[i] = TERM;

    repeat (3) @(posedge clk);
    #1;
    check("reset/ram_addr", ram_addr, 0);
    check("reset/busy", busy, 0);
    check("reset/done", done, 0);
    check("reset/error", error, 0);
    check("reset/err_index", err_index, 0);
    check("reset/scl_oe", scl_oe, 0);
    check("reset/sda_oe", sda_oe, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // single transaction then terminator
    ram[0] = 24'h980106;
    ram[1] = TERM;
    run_seq("basic", 0);

    // terminator at entry 0
    ram[0] = TERM;
    run_seq("term0", 0);

    // NACK on the register byte of entry 2
    for (int i = 0; i < 5; i++) ram[i] = rand_word();
    ram[5] = TERM;
    clear_policy();
    nack_at[2] = 1;
    run_seq("nack_reg", 0);

    // entry 1 NACKed twice, then ACKed
    clear_policy();
    nack_at[1] = 0;
    nack_at[2] = 2;
    run_seq("nack_twice", 0);

    // entry 1 NACKed persistently
    clear_policy();
    for (int f = 1; f < 10; f++) nack_at[f] = $urandom_range(0, 2);
    run_seq("nack_persist", 0);

    // randomized tables and slave behaviour
    for (int r = 0; r < 4; r++) begin
      int len;
      len = $urandom_range(1, 5);
      for (int i = 0; i < len; i++) ram[i] = rand_word();
      ram[len] = TERM;
      clear_policy();
      for (int f = 0; f < 16; f++)
        if ($urandom_range(0, 3) == 0) nack_at[f] = $urandom_range(0, 2);
      run_seq("random", 0);
    end

    // start pulsed again while busy
    for (int i = 0; i < 3; i++) ram[i] = rand_word();
    ram[3] = TERM;
    clear_policy();
    run_seq("restart_ignored", 1);

    // rst in the middle of the first byte, then a fresh run
    ram[0] = 24'h980106;
    ram[1] = TERM;
    clear_policy();
    @(posedge clk); #1;
    mon_clear = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    mon_clear = 1'b0;
    repeat (3 + 4*DIV + 4) @(posedge clk);
    #1;
    check("midreset/busy_before", busy, 1);
    check("midreset/scl_before", scl_oe, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midreset/scl_oe", scl_oe, 0);
    check("midreset/sda_oe", sda_oe, 0);
    check("midreset/busy", busy, 0);
    check("midreset/done", done, 0);
    rst = 1'b0;
    run_seq("replay", 0);

    // all 64 entries carry transactions
    for (int i = 0; i < 64; i++) ram[i] = rand_word();
    clear_policy();
    run_seq("full64", 0);
    check("full64/ram_addr_end", ram_addr, 63);
    repeat (5) @(posedge clk);
    #1;
    check("full64/ram_addr_hold", ram_addr, 63);
    check("full64/done_sticky", done, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
